// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Requests pass through combinationally while granted; a wait counter aborts stalled transfers.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wcnt_q, wcnt_d;

    logic busy, sel, req_vld, done, tmo;

    always_comb begin
        busy    = (state_q != IDLE);
        sel     = (state_q == BUSY1);
        req_vld = sel ? m1_valid : m0_valid;
        // A dropped request masks both completion and timeout.
        done    = busy & req_vld & mem_ready;
        tmo     = busy & req_vld & ~mem_ready & (wcnt_q == WCNT_LAST);
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (busy) begin
            mem_valid = sel ? m1_valid : m0_valid;
            mem_instr = sel ? m1_instr : m0_instr;
            mem_addr  = sel ? m1_addr  : m0_addr;
            mem_wdata = sel ? m1_wdata : m0_wdata;
            mem_wstrb = sel ? m1_wstrb : m0_wstrb;
        end
    end

    always_comb begin
        timeout  = tmo;
        m0_ready = (state_q == BUSY0) & (done | tmo);
        m1_ready = (state_q == BUSY1) & (done | tmo);
        m0_rdata = ((state_q == BUSY0) && done) ? mem_rdata : 32'h0;
        m1_rdata = ((state_q == BUSY1) && done) ? mem_rdata : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (m0_valid && m1_valid) state_d = last_q ? BUSY0 : BUSY1;
                else if (m0_valid)        state_d = BUSY0;
                else if (m1_valid)        state_d = BUSY1;
            end
            BUSY0, BUSY1: begin
                if (!req_vld) begin
                    state_d = IDLE;
                end else if (done || tmo) begin
                    state_d = IDLE;
                    last_d  = sel;
                end else if (wcnt_q != 16'hFFFF) begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic checked by a queue scoreboard.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rv [2];
    logic        ri [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rs [2];
    logic        m0_ready, m1_ready, timeout;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(rv[0]), .m0_instr(ri[0]), .m0_addr(ra[0]), .m0_wdata(rw[0]), .m0_wstrb(rs[0]),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(rv[1]), .m1_instr(ri[1]), .m1_addr(ra[1]), .m1_wdata(rw[1]), .m1_wstrb(rs[1]),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .timeout(timeout)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        tmo;
        int          ncyc;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_all();
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ri[i] = 1'b0; ra[i] = '0; rw[i] = '0; rs[i] = '0;
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    // Random-phase requester and memory agents.
    bit          act    [2];
    bit          done_f [2];
    int          gap    [2];
    int          lat    [2];
    int          bcnt   [2];
    logic [31:0] rd     [2];
    bit          mon_en = 1'b0;

    task automatic drv_cycle(input bit issue_en);
        exp_t e;
        int   j;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (done_f[i]) begin
                act[i] = 1'b0; rv[i] = 1'b0; bcnt[i] = 0; done_f[i] = 1'b0;
                gap[i] = $urandom_range(0, 2);
            end
            if (!act[i] && issue_en) begin
                if (gap[i] > 0) gap[i]--;
                else begin
                    act[i]  = 1'b1;
                    rv[i]   = 1'b1;
                    ri[i]   = 1'($urandom_range(0, 1));
                    ra[i]   = {i[0], 31'($urandom)};
                    rw[i]   = $urandom;
                    rs[i]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    lat[i]  = $urandom_range(1, T + 2);
                    rd[i]   = $urandom;
                    bcnt[i] = 0;
                    // Memory answers in busy cycle lat; past TIMEOUT the arbiter aborts first.
                    e.tmo   = (lat[i] > T);
                    e.rdata = e.tmo ? 32'h0 : rd[i];
                    e.ncyc  = e.tmo ? T : lat[i];
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
        #1;
        if (mem_valid) begin
            j = int'(mem_addr[31]);
            bcnt[j]++;
            mem_ready = (bcnt[j] == lat[j]);
            mem_rdata = mem_ready ? rd[j] : $urandom;
        end else begin
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        @(negedge clk);
        done_f[0] = m0_ready;
        done_f[1] = m1_ready;
    endtask

    // Monitor: arbitration, bus routing, and scoreboard pops on each ready pulse.
    initial begin : monitor
        exp_t        e;
        int          own, cur_own, bc;
        bit          model_last, prev_mv, prev_rdy, prev_v0, prev_v1;
        logic        rdy  [2];
        logic [31:0] rdat [2];
        cur_own = 0; bc = 0; model_last = 1'b1;
        prev_mv = 1'b0; prev_rdy = 1'b0; prev_v0 = 1'b0; prev_v1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_mv = 1'b0; prev_rdy = 1'b0; prev_v0 = 1'b0; prev_v1 = 1'b0;
                model_last = 1'b1; bc = 0; cur_own = 0;
            end else begin
                rdy[0] = m0_ready; rdy[1] = m1_ready;
                rdat[0] = m0_rdata; rdat[1] = m1_rdata;
                if (prev_rdy) chk1("idle_gap", mem_valid, 1'b0);
                if (mem_valid && !prev_mv) begin
                    own = (prev_v0 && prev_v1) ? int'(!model_last) : (prev_v0 ? 0 : 1);
                    chk("grant", {31'b0, mem_addr[31]}, 32'(own));
                    cur_own = own;
                    bc = 0;
                end
                if (mem_valid) begin
                    bc++;
                    chk("mem_addr", mem_addr, ra[cur_own]);
                    chk("mem_wdata", mem_wdata, rw[cur_own]);
                    chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, rs[cur_own]});
                    chk1("mem_instr", mem_instr, ri[cur_own]);
                end else begin
                    chk("idle_bus", mem_addr | mem_wdata | {27'b0, mem_instr, mem_wstrb}, 32'h0);
                end
                for (int i = 0; i < 2; i++) begin
                    if (rdy[i]) begin
                        chk("ready_owner", 32'(i), 32'(cur_own));
                        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL ready_unexpected: requester %0d pulsed ready with nothing outstanding", i);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk("rdata", rdat[i], e.rdata);
                            chk1("timeout", timeout, e.tmo);
                            chk("latency", 32'(bc), 32'(e.ncyc));
                        end
                        model_last = i[0];
                    end else begin
                        chk("rdata_idle", rdat[i], 32'h0);
                    end
                end
                if (!rdy[0] && !rdy[1]) chk1("timeout_quiet", timeout, 1'b0);
                prev_mv  = mem_valid;
                prev_rdy = rdy[0] | rdy[1];
                prev_v0  = rv[0];
                prev_v1  = rv[1];
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit drained;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; done_f[i] = 1'b0; gap[i] = 0; lat[i] = 0; bcnt[i] = 0; rd[i] = '0;
        end
        // Reset holds every output low even with live inputs.
        clr_all();
        rv[0] = 1'b1; ra[0] = 32'h44; mem_ready = 1'b1; mem_rdata = 32'h99;
        #3;
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_m0_ready", m0_ready, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        tick(); clr_all(); reset = 1'b1;

        // m0 read, memory answers two cycles after the first busy cycle.
        tick(); rv[0] = 1'b1; ra[0] = 32'h100;
        smp(); chk1("d1_idle", mem_valid, 1'b0);
        tick(); smp();
        chk1("d1_mem_valid", mem_valid, 1'b1);
        chk("d1_mem_addr", mem_addr, 32'h100);
        tick(); smp();
        tick(); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        smp();
        chk1("d1_m0_ready", m0_ready, 1'b1);
        chk("d1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk1("d1_m1_ready", m1_ready, 1'b0);
        chk("d1_m1_rdata", m1_rdata, 32'h0);
        tick(); clr_all();
        smp(); chk1("d1_after", m0_ready, 1'b0);

        // m1 byte write.
        tick(); rv[1] = 1'b1; ra[1] = 32'h200; rw[1] = 32'h12345678; rs[1] = 4'b0011;
        smp();
        tick(); smp();
        chk1("d2_mem_valid", mem_valid, 1'b1);
        chk("d2_wstrb", {28'b0, mem_wstrb}, 32'h3);
        chk("d2_wdata", mem_wdata, 32'h12345678);
        chk1("d2_wait", m1_ready, 1'b0);
        tick(); mem_ready = 1'b1; mem_rdata = 32'h55;
        smp();
        chk1("d2_m1_ready", m1_ready, 1'b1);
        chk1("d2_m0_ready", m0_ready, 1'b0);
        chk("d2_m1_rdata", m1_rdata, 32'h55);
        tick(); clr_all();

        // Stalled memory: abort in the fourth busy cycle.
        rv[0] = 1'b1; ra[0] = 32'h300; mem_rdata = 32'hFFFFFFFF;
        smp();
        for (int c = 1; c <= 4; c++) begin
            tick(); smp();
            chk1($sformatf("d3_timeout_c%0d", c), timeout, c == 4);
            chk1($sformatf("d3_m0_ready_c%0d", c), m0_ready, c == 4);
            if (c == 4) chk("d3_m0_rdata", m0_rdata, 32'h0);
        end
        tick(); clr_all();
        smp();
        chk1("d3_idle", mem_valid, 1'b0);
        chk1("d3_timeout_clear", timeout, 1'b0);

        // mem_ready on the timeout cycle is a normal completion.
        tick(); rv[1] = 1'b1; ra[1] = 32'h400;
        smp();
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) begin mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D; end
            smp();
            if (c < 4) chk1($sformatf("d4_wait_c%0d", c), m1_ready, 1'b0);
        end
        chk1("d4_m1_ready", m1_ready, 1'b1);
        chk("d4_m1_rdata", m1_rdata, 32'hCAFEF00D);
        chk1("d4_timeout", timeout, 1'b0);
        tick(); clr_all();

        // Both requesters always valid, memory always ready: 0,1,0,1 every other cycle.
        tick(); rv[0] = 1'b1; rv[1] = 1'b1; ra[0] = 32'h500; ra[1] = 32'h600;
        mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
        smp(); chk1("d5_idle", m0_ready, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick(); smp();
            chk1($sformatf("d5_m0_ready_%0d", k), m0_ready, (k % 4) == 1);
            chk1($sformatf("d5_m1_ready_%0d", k), m1_ready, (k % 4) == 3);
        end
        tick(); clr_all();

        // Reset in the second busy cycle, then a tie after release.
        tick(); rv[0] = 1'b1; rv[1] = 1'b1; ra[0] = 32'h1000; ra[1] = 32'h2000;
        smp();
        tick(); smp(); chk("d6_grant0", mem_addr, 32'h1000);
        tick(); mem_ready = 1'b1; mem_rdata = 32'h77;
        #1; reset = 1'b0; #1;
        chk1("d6_rst_mem_valid", mem_valid, 1'b0);
        chk1("d6_rst_m0_ready", m0_ready, 1'b0);
        chk("d6_rst_m0_rdata", m0_rdata, 32'h0);
        chk1("d6_rst_timeout", timeout, 1'b0);
        chk("d6_rst_mem_addr", mem_addr, 32'h0);
        tick(); mem_ready = 1'b0;
        tick(); reset = 1'b1;
        smp(); chk1("d6_idle_after_rst", mem_valid, 1'b0);
        tick(); smp();
        chk1("d6_first_edge_valid", mem_valid, 1'b1);
        chk("d6_first_edge_addr", mem_addr, 32'h1000);

        // Requester withdraws mid-transfer; the following tie still favours m0.
        tick(); rv[0] = 1'b0; rv[1] = 1'b0; mem_ready = 1'b1;
        smp();
        chk1("d7_no_ready", m0_ready, 1'b0);
        chk1("d7_mem_valid", mem_valid, 1'b0);
        chk1("d7_timeout", timeout, 1'b0);
        tick(); rv[0] = 1'b1; rv[1] = 1'b1;
        smp();
        chk1("d7_idle_ign_m0", m0_ready, 1'b0);
        chk1("d7_idle_ign_m1", m1_ready, 1'b0);
        tick(); mem_ready = 1'b0;
        smp();
        chk1("d7_tie_valid", mem_valid, 1'b1);
        chk("d7_tie_grant0", mem_addr, 32'h1000);
        tick(); mem_ready = 1'b1;
        smp(); chk1("d7_done", m0_ready, 1'b1);
        tick(); clr_all();

        // Random traffic against the scoreboard.
        reset = 1'b0;
        tick(); reset = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 1500; k++) drv_cycle(1'b1);
        drained = 1'b0;
        for (int k = 0; k < 200 && !drained; k++) begin
            drv_cycle(1'b0);
            drained = (!act[0] || done_f[0]) && (!act[1] || done_f[1]);
        end
        chk1("drain", drained, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'h0);
        chk("q1_empty", 32'(q1.size()), 32'h0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles without mem_ready before a transaction is aborted (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports m0_valid / m1_valid, input, 1 bit each: requester i has a transaction pending.
REQ-005 The block SHALL have ports m0_instr / m1_instr, input, 1 bit each: requester i's transaction is an instruction fetch.
REQ-006 The block SHALL have ports m0_addr / m1_addr, input, 32 bits each: requester i's byte address.
REQ-007 The block SHALL have ports m0_wdata / m1_wdata, input, 32 bits each: requester i's write data.
REQ-008 The block SHALL have ports m0_wstrb / m1_wstrb, input, 4 bits each: requester i's byte write strobes; 0 means read.
REQ-009 The block SHALL have ports m0_ready / m1_ready, output, 1 bit each: one-cycle pulse marking completion of requester i's transaction.
REQ-010 The block SHALL have ports m0_rdata / m1_rdata, output, 32 bits each: read data for requester i, valid while mi_ready=1.
REQ-011 The block SHALL have ports mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0], all outputs: the shared downstream request.
REQ-012 The block SHALL have ports mem_ready, input, 1 bit, and mem_rdata, input, 32 bits: the downstream response.
REQ-013 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a timeout abort.

Function
REQ-014 The block SHALL implement the states IDLE, BUSY0 and BUSY1, plus a 1-bit last-served pointer `last` and a 16-bit wait counter `wcnt`.
REQ-015 In IDLE, when exactly one mi_valid=1, the block SHALL enter BUSYi on the next edge.
REQ-016 In IDLE, when both mi_valid=1, the block SHALL enter BUSYi with i = ~last (round-robin).
REQ-017 On entry to BUSYi the block SHALL clear wcnt to 0.
REQ-018 In BUSYi, mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb SHALL combinationally equal requester i's inputs; in IDLE they SHALL all be 0.
REQ-019 In BUSYi, when mem_valid & mem_ready: mi_ready SHALL be 1 and mi_rdata SHALL equal mem_rdata in that cycle, last SHALL be set to i, and the next state SHALL be IDLE.
REQ-020 The non-granted requester's ready SHALL be 0 and its rdata SHALL be 32'h0 at all times.
REQ-021 Each grant SHALL be followed by at least one IDLE cycle (minimum request-to-ready latency 1 cycle; back-to-back throughput 1 transaction per 2 cycles).
REQ-022 In BUSYi with mem_ready=0, wcnt SHALL increment by 1 per cycle, saturating at 16'hFFFF.
REQ-023 In BUSYi, when wcnt == TIMEOUT-1 and mem_ready=0: mi_ready=1 with mi_rdata=32'h0, timeout=1 for that cycle only, last=i, next state IDLE.
REQ-024 mem_ready=1 in the same cycle as the timeout condition SHALL count as a normal completion, with timeout=0.
REQ-025 If mi_valid drops while in BUSYi (protocol violation), the block SHALL return to IDLE next cycle without pulsing mi_ready, and last SHALL be unchanged.
REQ-026 mem_ready asserted while in IDLE SHALL be ignored.
REQ-027 All outputs SHALL be functions of state and the present inputs only; no requester data SHALL be registered.

Reset
REQ-028 While reset=0, the block SHALL force state=IDLE, last=1 (so requester 0 wins the first tie), wcnt=0, and all outputs to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no ready or timeout pulse.
REQ-030 After reset deasserts, the block SHALL accept a request on the first clock edge.

Verification
REQ-031 Scenario: m0 read at addr 32'h100 with mem_ready high 2 cycles after grant and mem_rdata=32'hDEADBEEF -> m0_ready pulses one cycle with m0_rdata=32'hDEADBEEF; m1_ready stays 0.
REQ-032 Scenario: both requesters held valid continuously after reset, mem_ready always 1 -> grant order 0,1,0,1; each mi_ready pulse is 2 cycles apart.
REQ-033 Scenario: m1 write, wstrb=4'b0011, wdata=32'h12345678 -> mem_wstrb=4'b0011 and mem_wdata=32'h12345678 while BUSY1; m1_ready pulses on mem_ready.
REQ-034 Scenario: TIMEOUT=4, mem_ready held 0 -> timeout and m0_ready pulse together in the 4th BUSY cycle with m0_rdata=0; state returns to IDLE.
REQ-035 Scenario: reset=0 in the 2nd BUSY0 cycle -> all outputs 0 asynchronously; after release, a tie grants requester 0.
REQ-036 Scenario: m0_valid dropped in BUSY0 before mem_ready -> IDLE next cycle, no ready pulse, and a following tie still grants requester 0.
